// File: rtl/controlador_hd_pkg.sv
// Shared definitions for the disk controller: FSM encodings, operation type and default geometry.
package controlador_hd_pkg;

  localparam int HD_DATA_W          = 32;
  localparam int HD_N_TRACKS        = 16;
  localparam int HD_WORDS_PER_TRACK = 64;
  localparam int HD_SEEK_CYC        = 2;
  localparam int HD_XFER_CYC        = 1;

  typedef enum logic [1:0] {
    HD_IDLE = 2'd0,
    HD_SEEK = 2'd1,
    HD_XFER = 2'd2,
    HD_DONE = 2'd3
  } hd_state_t;

  typedef enum logic {
    HD_OP_READ  = 1'b0,
    HD_OP_WRITE = 1'b1
  } hd_op_t;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hd_armazenamento.sv
// Disk platter contents: single-port word array with synchronous write and combinational read.
module hd_armazenamento #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  // Contents survive reset so an aborted write leaves the old word in place.
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/controlador_hd.sv
// Disk-side responder: accepts one read/write, models seek + transfer latency, then commits or returns data.
module controlador_hd
  import controlador_hd_pkg::*;
#(
  parameter int DATA_W          = HD_DATA_W,
  parameter int N_TRACKS        = HD_N_TRACKS,
  parameter int WORDS_PER_TRACK = HD_WORDS_PER_TRACK,
  parameter int SEEK_CYC        = HD_SEEK_CYC,
  parameter int XFER_CYC        = HD_XFER_CYC
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        Sel_HD_w,
  input  logic                        Sel_HD_r,
  input  logic [31:0]                 hd_addr,
  input  logic [DATA_W-1:0]           hd_wdata,
  output logic [DATA_W-1:0]           HD_out,
  output logic                        busy,
  output logic                        done,
  output logic                        hd_err,
  output logic [$clog2(N_TRACKS)-1:0] head_pos
);

  localparam int ADDR_W = $clog2(N_TRACKS * WORDS_PER_TRACK);
  localparam int TRK_W  = $clog2(N_TRACKS);
  localparam int WRD_W  = $clog2(WORDS_PER_TRACK);
  localparam int SEEK_W = $clog2(N_TRACKS * SEEK_CYC) + 1;
  localparam int XFER_W = $clog2(XFER_CYC) + 1;
  localparam int CNT_W  = maxInt(SEEK_W, XFER_W);

  hd_state_t         r_state;
  hd_state_t         w_stateNext;
  hd_op_t            r_op;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [TRK_W-1:0]  r_tgtTrack;
  logic [TRK_W-1:0]  r_headPos;
  logic [DATA_W-1:0] r_hdOut;
  logic              r_hdErr;

  logic              w_addrOk;
  logic              w_valid;
  logic              w_invalid;
  logic [TRK_W-1:0]  w_tgtTrack;
  logic [TRK_W-1:0]  w_dist;
  logic [CNT_W-1:0]  w_seekCnt;
  logic              w_xferEnd;
  logic              w_we;
  logic [DATA_W-1:0] w_rdata;

  assign w_addrOk   = (hd_addr[31:ADDR_W] == '0);
  assign w_valid    = (Sel_HD_w ^ Sel_HD_r) & w_addrOk;
  assign w_invalid  = (Sel_HD_w | Sel_HD_r) & ~w_valid;
  assign w_tgtTrack = hd_addr[ADDR_W-1:WRD_W];
  assign w_dist     = (w_tgtTrack >= r_headPos) ? (w_tgtTrack - r_headPos)
                                                : (r_headPos - w_tgtTrack);
  assign w_seekCnt  = CNT_W'(w_dist) * CNT_W'(SEEK_CYC);
  assign w_xferEnd  = (r_state == HD_XFER) && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= HD_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    busy        = (r_state != HD_IDLE);
    done        = (r_state == HD_DONE);
    // Reset gates the write so an operation caught by reset never lands.
    w_we        = w_xferEnd && (r_op == HD_OP_WRITE) && !reset;
    case (r_state)
      HD_IDLE: begin
        if (w_valid) begin
          w_stateNext = (w_seekCnt != '0) ? HD_SEEK : HD_XFER;
        end else if (w_invalid) begin
          w_stateNext = HD_DONE;
        end
      end
      HD_SEEK: if (r_cnt == CNT_W'(1)) w_stateNext = HD_XFER;
      HD_XFER: if (r_cnt == '0) w_stateNext = HD_DONE;
      default: w_stateNext = HD_IDLE;
    endcase
  end

  // Head only moves at the end of the seek, so an aborted seek never reaches the target.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op       <= HD_OP_READ;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_tgtTrack <= '0;
      r_headPos  <= '0;
      r_hdOut    <= '0;
      r_hdErr    <= 1'b0;
    end else begin
      case (r_state)
        HD_IDLE: begin
          if (w_valid) begin
            r_op       <= Sel_HD_w ? HD_OP_WRITE : HD_OP_READ;
            r_addr     <= hd_addr[ADDR_W-1:0];
            r_wdata    <= hd_wdata;
            r_tgtTrack <= w_tgtTrack;
            r_hdErr    <= 1'b0;
            r_cnt      <= (w_seekCnt != '0) ? w_seekCnt : CNT_W'(XFER_CYC - 1);
          end else if (w_invalid) begin
            r_hdErr <= 1'b1;
          end
        end
        HD_SEEK: begin
          if (r_cnt == CNT_W'(1)) begin
            r_headPos <= r_tgtTrack;
            r_cnt     <= CNT_W'(XFER_CYC - 1);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        HD_XFER: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else if (r_op == HD_OP_READ) begin
            r_hdOut <= w_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  hd_armazenamento #(
    .DATA_W (DATA_W),
    .DEPTH  (N_TRACKS * WORDS_PER_TRACK),
    .ADDR_W (ADDR_W)
  ) u_armazenamento (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_addr  (r_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  assign HD_out   = r_hdOut;
  assign hd_err   = r_hdErr;
  assign head_pos = r_headPos;

endmodule

// File: tb/tb_controlador_hd.sv
// Directed bench for controlador_hd: latency, data return, error handling and reset abort.
module tb_controlador_hd;

  logic        clk;
  logic        reset;
  logic        Sel_HD_w;
  logic        Sel_HD_r;
  logic [31:0] hd_addr;
  logic [31:0] hd_wdata;
  logic [31:0] HD_out;
  logic        busy;
  logic        done;
  logic        hd_err;
  logic [3:0]  head_pos;

  int nChecks = 0;
  int nErrors = 0;

  controlador_hd dut (
    .clk      (clk),
    .reset    (reset),
    .Sel_HD_w (Sel_HD_w),
    .Sel_HD_r (Sel_HD_r),
    .hd_addr  (hd_addr),
    .hd_wdata (hd_wdata),
    .HD_out   (HD_out),
    .busy     (busy),
    .done     (done),
    .hd_err   (hd_err),
    .head_pos (head_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one request from IDLE and returns in the done cycle (#1 after its edge).
  task automatic applyStimulus(input logic w, input logic r, input logic [31:0] addr,
                               input logic [31:0] data, input int expLat, input string tag);
    int lat;
    if (done === 1'b1) begin
      @(posedge clk); #1;
    end
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    Sel_HD_w = w;
    Sel_HD_r = r;
    hd_addr  = addr;
    hd_wdata = data;
    @(posedge clk); #1;
    Sel_HD_w = 1'b0;
    Sel_HD_r = 1'b0;
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
  endtask

  initial begin
    reset    = 1'b1;
    Sel_HD_w = 1'b0;
    Sel_HD_r = 1'b0;
    hd_addr  = 32'd0;
    hd_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err",  32'(hd_err), 32'd0);
    checkOutput("rst_out",  HD_out, 32'd0);
    checkOutput("rst_head", 32'(head_pos), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Same-track write and read back
    applyStimulus(1'b1, 1'b0, 32'd5, 32'hDEADBEEF, 2, "w5");
    checkOutput("w5_err",  32'(hd_err), 32'd0);
    checkOutput("w5_head", 32'(head_pos), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'd5, 32'd0, 2, "r5");
    checkOutput("r5_out", HD_out, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 32'd7, 32'hCAFE0007, 2, "w7");
    applyStimulus(1'b1, 1'b0, 32'd0, 32'h0BAD0000, 2, "w0");
    checkOutput("w0_out_held", HD_out, 32'hDEADBEEF);

    // Seek to track 3 and back
    applyStimulus(1'b1, 1'b0, 32'd199, 32'h00001234, 8, "w199");
    checkOutput("w199_head", 32'(head_pos), 32'd3);
    checkOutput("w199_out_held", HD_out, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b1, 32'd7, 32'd0, 8, "r7");
    checkOutput("r7_out",  HD_out, 32'hCAFE0007);
    checkOutput("r7_head", 32'(head_pos), 32'd0);

    // Both requests at once
    applyStimulus(1'b1, 1'b1, 32'd0, 32'hFFFFFFFF, 1, "both");
    checkOutput("both_err",  32'(hd_err), 32'd1);
    checkOutput("both_out",  HD_out, 32'hCAFE0007);
    checkOutput("both_head", 32'(head_pos), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'd199, 32'd0, 8, "r199");
    checkOutput("r199_err",  32'(hd_err), 32'd0);
    checkOutput("r199_out",  HD_out, 32'h00001234);
    checkOutput("r199_head", 32'(head_pos), 32'd3);

    // Out-of-range address
    applyStimulus(1'b1, 1'b0, 32'h00000400, 32'h55555555, 1, "oor");
    checkOutput("oor_err",  32'(hd_err), 32'd1);
    checkOutput("oor_head", 32'(head_pos), 32'd3);
    checkOutput("oor_out",  HD_out, 32'h00001234);
    applyStimulus(1'b0, 1'b1, 32'd0, 32'd0, 8, "r0");
    checkOutput("r0_err", 32'(hd_err), 32'd0);
    checkOutput("r0_out", HD_out, 32'h0BAD0000);

    // Reset during seek aborts the write
    applyStimulus(1'b1, 1'b0, 32'd513, 32'h88880001, 18, "w513");
    checkOutput("w513_head", 32'(head_pos), 32'd8);
    applyStimulus(1'b1, 1'b0, 32'd768, 32'h0C0C0C0C, 10, "w768");
    checkOutput("w768_head", 32'(head_pos), 32'd12);
    @(posedge clk); #1;
    Sel_HD_w = 1'b1;
    hd_addr  = 32'd513;
    hd_wdata = 32'h99999999;
    @(posedge clk); #1;
    Sel_HD_w = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_inseek", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_head", 32'(head_pos), 32'd0);
    checkOutput("abort_out",  HD_out, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'd513, 32'd0, 18, "r513");
    checkOutput("r513_out",  HD_out, 32'h88880001);
    checkOutput("r513_head", 32'(head_pos), 32'd8);
    applyStimulus(1'b0, 1'b1, 32'd768, 32'd0, 10, "r768");
    checkOutput("r768_out", HD_out, 32'h0C0C0C0C);
    @(posedge clk); #1;
    checkOutput("end_done", 32'(done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
